// File: rtl/path_mon_pkg.sv
// Shared types and constants for the path monitor.
package path_mon_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_TOUT  = 3'd5
  } state_e;

  localparam logic [31:0] ADDR_NODE_DEF = 32'h0200_0008;
  localparam logic [31:0] ADDR_DONE_DEF = 32'h0200_000c;

  // Width of the node/error counters: they must reach DEPTH+1 (one extra node).
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/path_exp_mem.sv
// Expected-node buffer: one write port, one asynchronous read port.
module path_exp_mem #(
  parameter int DEPTH  = 16,
  parameter int NODE_W = 5,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [NODE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [NODE_W-1:0] rdata
);

  logic [NODE_W-1:0] mem_q [DEPTH];

  // Contents need no reset; only entries below exp_cnt are ever read.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/path_monitor.sv
// Snoops CPU bus writes of node points and checks them against a loaded path.
module path_monitor
  import path_mon_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter int          NODE_W      = 5,
  parameter logic [31:0] ADDR_NODE   = ADDR_NODE_DEF,
  parameter logic [31:0] ADDR_DONE   = ADDR_DONE_DEF,
  parameter int          TIMEOUT_CYC = 100000,
  localparam int         CW          = cnt_w(DEPTH),
  localparam int         EW          = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              exp_valid,
  input  logic [NODE_W-1:0] exp_data,
  input  logic              exp_last,
  output logic              exp_ready,
  input  logic              start,
  input  logic              MemWrite,
  input  logic [31:0]       DataAdr,
  input  logic [31:0]       WriteData,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CW-1:0]     error_count,
  output logic [CW-1:0]     node_count,
  output logic [EW-1:0]     first_err_idx
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [EW-1:0] DEPTH_V = EW'(DEPTH);
  localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [EW-1:0]     exp_cnt_q, exp_cnt_d;
  logic [CW-1:0]     node_q, node_d;
  logic [CW-1:0]     err_q, err_d;
  logic [EW-1:0]     ferr_q, ferr_d;
  logic [TW-1:0]     cyc_q, cyc_d;
  logic [NODE_W-1:0] exp_rd;
  logic              exp_acc, node_wr, done_wr, extra, bad, err_ev;

  path_exp_mem #(.DEPTH(DEPTH), .NODE_W(NODE_W)) u_mem (
    .clk  (clk),
    .we   (exp_acc),
    .waddr(exp_cnt_q[AW-1:0]),
    .wdata(exp_data),
    .raddr(node_q[AW-1:0]),
    .rdata(exp_rd)
  );

  // Bus decode; only meaningful while running.
  always_comb begin
    exp_acc = exp_valid && exp_ready;
    node_wr = (state_q == S_RUN) && MemWrite && (DataAdr == ADDR_NODE);
    done_wr = (state_q == S_RUN) && MemWrite && (DataAdr == ADDR_DONE) && (WriteData == 32'd1);
    extra   = node_q >= CW'(exp_cnt_q);
    // !== makes X/Z on the bus a mismatch in simulation; synthesizes as !=.
    bad     = (WriteData[31:NODE_W] !== '0) || (WriteData[NODE_W-1:0] !== exp_rd);
    err_ev  = (node_wr && (extra || bad)) || (done_wr && (node_q < CW'(exp_cnt_q)));
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a done write beats the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    if (clear) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (exp_acc) state_d = exp_last ? S_READY : S_LOAD;
        S_LOAD:  if (exp_acc && exp_last) state_d = S_READY;
        S_READY: if (start) state_d = S_RUN;
        S_RUN: begin
          if (done_wr)             state_d = S_DONE;
          else if (cyc_q == TLAST) state_d = S_TOUT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs decoded from state and counters.
  always_comb begin
    exp_ready     = ((state_q == S_IDLE) || (state_q == S_LOAD)) && (exp_cnt_q < DEPTH_V);
    busy          = state_q == S_RUN;
    done          = (state_q == S_DONE) || (state_q == S_TOUT);
    timeout       = state_q == S_TOUT;
    pass          = (state_q == S_DONE) && (err_q == '0) && (node_q != '0);
    error_count   = err_q;
    node_count    = node_q;
    first_err_idx = ferr_q;
  end

  // Counter updates: load count, node/error tallies, RUN cycle count.
  always_comb begin
    exp_cnt_d = exp_cnt_q;
    node_d    = node_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    cyc_d     = cyc_q;
    if (clear) begin
      exp_cnt_d = '0;
      node_d    = '0;
      err_d     = '0;
      ferr_d    = '1;
      cyc_d     = '0;
    end else begin
      if (exp_acc) exp_cnt_d = exp_cnt_q + 1'b1;
      if (state_q == S_RUN) cyc_d = cyc_q + 1'b1;
      if (node_wr && (node_q != '1)) node_d = node_q + 1'b1;
      if (err_ev) begin
        if (err_q != '1)  err_d  = err_q + 1'b1;
        if (ferr_q == '1) ferr_d = EW'(node_q);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_cnt_q <= '0;
      node_q    <= '0;
      err_q     <= '0;
      ferr_q    <= '1;
      cyc_q     <= '0;
    end else begin
      exp_cnt_q <= exp_cnt_d;
      node_q    <= node_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      cyc_q     <= cyc_d;
    end
  end

endmodule

// File: tb/tb_path_monitor.sv
// Directed bench for path_monitor (DEPTH=16, TIMEOUT_CYC=50).
module tb_path_monitor;
  localparam logic [31:0] AN = 32'h0200_0008;
  localparam logic [31:0] AD = 32'h0200_000c;

  logic        clk = 1'b0;
  logic        reset, clear, exp_valid, exp_last, start, MemWrite;
  logic [4:0]  exp_data;
  logic [31:0] DataAdr, WriteData;
  logic        exp_ready, busy, done, pass, timeout;
  logic [4:0]  error_count, node_count, first_err_idx;

  int n_chk = 0;
  int n_fail = 0;

  path_monitor #(.DEPTH(16), .NODE_W(5), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .reset(reset), .clear(clear), .exp_valid(exp_valid),
    .exp_data(exp_data), .exp_last(exp_last), .exp_ready(exp_ready),
    .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .node_count(node_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic push(input logic [4:0] d, input logic l);
    exp_valid = 1'b1; exp_data = d; exp_last = l;
    tick();
    exp_valid = 1'b0; exp_last = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
  endtask

  task automatic load_start();
    push(5'd4, 1'b0); push(5'd7, 1'b0); push(5'd12, 1'b0); push(5'd3, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},  exp_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_tout"}, timeout, 0);
    chk({tag, "_err"},  error_count, 0);
    chk({tag, "_node"}, node_count, 0);
    chk({tag, "_fidx"}, first_err_idx, 5'h1f);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; exp_valid = 1'b0; exp_last = 1'b0; exp_data = '0;
    start = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    tick(2);
    reset = 1'b0;
    chk_reset_vals("rst");

    // Clean run
    push(5'd4, 1'b0);
    chk("load_rdy", exp_ready, 1);
    push(5'd7, 1'b0); push(5'd12, 1'b0); push(5'd3, 1'b1);
    chk("ready_rdy", exp_ready, 0);
    wr(AN, 32'd4);                      // outside RUN: ignored
    chk("pre_run_node", node_count, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("run_busy", busy, 1);
    wr(AN, 32'd4); wr(AN, 32'd7);
    chk("mid_node", node_count, 2);
    wr(AN, 32'd12); wr(AN, 32'd3);
    wr(AD, 32'd1);
    chk("ok_done", done, 1);
    chk("ok_pass", pass, 1);
    chk("ok_err", error_count, 0);
    chk("ok_node", node_count, 4);
    chk("ok_busy", busy, 0);
    tick(3);
    chk("ok_hold", done, 1);
    do_clear();
    chk("clr_done", done, 0);
    chk("clr_node", node_count, 0);

    // One wrong node
    load_start();
    wr(AN, 32'd4); wr(AN, 32'd9); wr(AN, 32'd12); wr(AN, 32'd3); wr(AD, 32'd1);
    chk("mm_pass", pass, 0);
    chk("mm_err", error_count, 1);
    chk("mm_fidx", first_err_idx, 1);
    chk("mm_done", done, 1);
    do_clear();

    // Upper bits set count as a mismatch
    load_start();
    wr(AN, 32'h0000_0104); wr(AN, 32'd7); wr(AN, 32'd12); wr(AN, 32'd3); wr(AD, 32'd1);
    chk("hi_err", error_count, 1);
    chk("hi_fidx", first_err_idx, 0);
    do_clear();

    // Missing nodes
    load_start();
    wr(AN, 32'd4); wr(AN, 32'd7); wr(AD, 32'd1);
    chk("miss_err", error_count, 1);
    chk("miss_pass", pass, 0);
    chk("miss_fidx", first_err_idx, 2);
    do_clear();

    // Extra node
    load_start();
    wr(AN, 32'd4); wr(AN, 32'd7); wr(AN, 32'd12); wr(AN, 32'd3); wr(AN, 32'd5); wr(AD, 32'd1);
    chk("extra_err", error_count, 1);
    chk("extra_node", node_count, 5);
    chk("extra_fidx", first_err_idx, 4);
    chk("extra_pass", pass, 0);
    do_clear();

    // Timeout after 50 RUN cycles
    load_start();
    tick(49);
    chk("to_49_busy", busy, 1);
    chk("to_49_tout", timeout, 0);
    tick();
    chk("to_tout", timeout, 1);
    chk("to_done", done, 1);
    chk("to_pass", pass, 0);
    wr(AD, 32'd1);
    chk("to_hold", timeout, 1);
    do_clear();

    // Done write on RUN cycle 50 beats the timeout
    load_start();
    wr(AN, 32'd4); wr(AN, 32'd7); wr(AN, 32'd12); wr(AN, 32'd3);
    tick(45);
    wr(AD, 32'd1);
    chk("race_tout", timeout, 0);
    chk("race_done", done, 1);
    chk("race_pass", pass, 1);
    do_clear();

    // Overfill: 17th entry dropped, FSM stays in LOAD, start ignored
    for (int i = 0; i < 15; i++) push(5'(i), 1'b0);
    chk("fill15_rdy", exp_ready, 1);
    push(5'd15, 1'b0);
    chk("fill16_rdy", exp_ready, 0);
    push(5'd16, 1'b1);
    chk("drop_rdy", exp_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("load_start_busy", busy, 0);
    do_clear();
    chk("clr_rdy", exp_ready, 1);

    // Start in IDLE ignored; done=0 write ignored; reset mid-run
    start = 1'b1; tick(); start = 1'b0;
    chk("idle_start_busy", busy, 0);
    load_start();
    wr(AD, 32'd0);
    wr(32'h0200_0010, 32'd4);
    chk("d0_busy", busy, 1);
    chk("d0_done", done, 0);
    chk("other_node", node_count, 0);
    wr(AN, 32'd4);
    wr(AN, 32'd8);
    chk("pre_rst_err", error_count, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_reset_vals("mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
